branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
// - EX-stage branch resolution and front-end redirect controller for the 5-stage RV32I core.
// - Holds a BHT of 2-bit saturating counters that supplies taken/not-taken predictions to IF.
// - Evaluates the branch condition from Funct3 and the ALU result, then compares it with the
//   prediction carried down the pipe.
// - On a mismatch it sequences a registered PC redirect plus IF/ID and ID/EX flush.
// PARAMETERS
// - WIDTH        32   datapath/PC width
// - BHT_ENTRIES  64   BHT depth, power of 2; index = pc[IDX_W+1:2], IDX_W = $clog2(BHT_ENTRIES)
// PORTS
// - clk            in   1      core clock, all state updates on rising edge
// - reset          in   1      synchronous, active-high
// - if_pc          in   WIDTH  fetch PC, used for the prediction lookup
// - pred_taken     out  1      combinational BHT prediction for if_pc (counter[1])
// - ex_valid       in   1      EX stage holds a valid instruction
// - stall          in   1      pipeline hold; EX contents do not advance
// - ex_pc          in   WIDTH  PC of the EX instruction
// - ex_branch      in   1      EX instruction is a conditional branch
// - ex_jump        in   1      EX instruction is JAL/JALR
// - ex_funct3      in   3      branch Funct3
// - ex_alu_result  in   WIDTH  ALU result (SUB for BEQ/BNE, SLT/SLTU for the others)
// - ex_pred_taken  in   1      prediction made in IF for this instruction
// - ex_target      in   WIDTH  computed branch/jump target
// - ex_pc_plus4    in   WIDTH  fall-through PC
// - redirect       out  1      load redirect_pc into the PC
// - redirect_pc    out  WIDTH  corrected PC
// - flush_ifid     out  1      squash IF/ID
// - flush_idex     out  1      squash ID/EX
// BEHAVIOUR
// - Actual outcome, combinational:
//   - act = ex_jump | (ex_branch & cond)
//   - cond by ex_funct3:
//     - 000: alu==0
//     - 001: alu!=0
//     - 100,110: alu[0]==1
//     - 101,111: alu[0]==0
//     - 010,011: 0
// - Resolve event: res = ex_valid & (ex_branch|ex_jump) & !stall & state==IDLE.
// - Mispredict: mis = res & (act != ex_pred_taken).
// - FSM states IDLE, REDIRECT.
//   - IDLE -> REDIRECT on mis. redirect_pc is registered as act ? ex_target : ex_pc_plus4.
//   - REDIRECT drives redirect=flush_ifid=flush_idex=1.
//     - stall=1: hold state and outputs unchanged.
//     - stall=0: -> IDLE next edge.
//   - EX inputs are ignored in REDIRECT because they are wrong-path.
// - Latency: mispredict seen in EX at cycle N -> redirect/flush asserted for cycle N+1 (min 1 cycle).
// - BHT update on res & ex_branch (jumps are never written):
//   - act=1: counter +1, saturating at 11.
//   - act=0: counter -1, saturating at 00.
//   - Index is taken from ex_pc.
// - Same-index read and write in the same cycle: pred_taken returns the pre-update value (no bypass).
// - Back-to-back mispredicts cannot occur: the second one is in a flushed slot.
// - Reset values:
//   - redirect=0, flush_ifid=0, flush_idex=0, redirect_pc=0
//   - state=IDLE
//   - every BHT counter = 01 (weakly not taken)
// - Reset mid-REDIRECT: outputs drop at the next edge and the BHT is reinitialised; reset wins over all.
// - ex_branch & ex_jump both set is illegal from decode; it is resolved as a jump.
// CONFIGURATION
// - BR_STATS_EN defined: adds ports
//   - stat_branches  out 32: count of res events
//   - stat_mispred   out 32: count of mis events
//   - Both wrap modulo 2^32, clear on reset, do not count while stall=1.
// - BR_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
// - Reset, then sample if_pc=0x0,0x4,0x100 -> pred_taken=0. Outputs 0, state IDLE.
// - Mispredicted taken: BEQ, alu=0, pred=0, target=0x40 -> next cycle redirect=1, redirect_pc=0x40,
//   both flushes=1 for exactly 1 cycle. BHT[idx] reaches 10.
// - Mispredicted not-taken: BNE, alu=0, pred=1, pc_plus4=0x24 -> redirect_pc=0x24.
//   Repeat the branch 3x -> counter saturates at 00.
// - Correct prediction: BLT, alu=1, pred=1 -> no redirect/flush. Counter increments, saturating at 11.
// - stall=1 during a mispredict cycle -> no redirect. stall=1 during REDIRECT -> outputs held
//   until stall=0, then one more cycle, then IDLE.
// - Assert reset during REDIRECT -> outputs 0 the next cycle, BHT back to 01.
//   With BR_STATS_EN: 5 branches, 2 mispredicts -> stats 5/2.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution, 2-bit BHT predictor and front-end redirect sequencer.
// Optional BR_STATS_EN adds resolved-branch and mispredict counters.
module branch_resolve_ctrl #(
    parameter int WIDTH       = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             stall,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [WIDTH-1:0] ex_alu_result,
    input  logic             ex_pred_taken,
    input  logic [WIDTH-1:0] ex_target,
    input  logic [WIDTH-1:0] ex_pc_plus4,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex
`ifdef BR_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispred
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       cur_cnt;
    logic [1:0]       bht_next;
    logic             bht_we;
    logic             cond;
    logic             act;
    logic             res;
    logic             mis;
    logic             unused_bits;

    assign rd_idx = if_pc[IDX_W+1:2];
    assign wr_idx = ex_pc[IDX_W+1:2];

    assign unused_bits = ^{if_pc[WIDTH-1:IDX_W+2], if_pc[1:0],
                           ex_pc[WIDTH-1:IDX_W+2], ex_pc[1:0]};

    // Lookup deliberately ignores a same-cycle write to the same entry.
    assign pred_taken = bht[rd_idx][1];

    always_comb begin
        cond = 1'b0;
        unique case (ex_funct3)
            3'b000:         cond = (ex_alu_result == '0);
            3'b001:         cond = (ex_alu_result != '0);
            3'b100, 3'b110: cond = ex_alu_result[0];
            3'b101, 3'b111: cond = ~ex_alu_result[0];
            default:        cond = 1'b0;
        endcase
    end

    assign act = ex_jump | (ex_branch & cond);
    assign res = ex_valid & (ex_branch | ex_jump) & ~stall & (state == IDLE);
    assign mis = res & (act != ex_pred_taken);

    // A branch+jump encoding resolves as a jump, so it never trains the BHT.
    assign bht_we  = res & ex_branch & ~ex_jump;
    assign cur_cnt = bht[wr_idx];

    always_comb begin
        bht_next = cur_cnt;
        if (act && cur_cnt != 2'b11) begin
            bht_next = cur_cnt + 2'b01;
        end else if (!act && cur_cnt != 2'b00) begin
            bht_next = cur_cnt - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_we) begin
            bht[wr_idx] <= bht_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        redirect   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        unique case (state)
            IDLE: begin
                if (mis) begin
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                redirect   = 1'b1;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                if (!stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_pc <= '0;
        end else if (mis) begin
            redirect_pc <= act ? ex_target : ex_pc_plus4;
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (res) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mis) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        stall;
    logic [31:0] ex_pc;
    logic        ex_branch;
    logic        ex_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_ifid;
    logic        flush_idex;
`ifdef BR_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    typedef struct {
        bit          redir;
        logic [31:0] pc;
        bit          ck_pc;
        bit          pred;
        bit          ck_pred;
    } exp_t;

    exp_t q[$];

    branch_resolve_ctrl dut (
        .clk(clk),
        .reset(reset),
        .if_pc(if_pc),
        .pred_taken(pred_taken),
        .ex_valid(ex_valid),
        .stall(stall),
        .ex_pc(ex_pc),
        .ex_branch(ex_branch),
        .ex_jump(ex_jump),
        .ex_funct3(ex_funct3),
        .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken),
        .ex_target(ex_target),
        .ex_pc_plus4(ex_pc_plus4),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .flush_ifid(flush_ifid),
        .flush_idex(flush_idex)
`ifdef BR_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks += 3;
            if (redirect !== e.redir) begin
                n_fail++;
                $display("FAIL redirect got %b exp %b t=%0t", redirect, e.redir, $time);
            end
            if (flush_ifid !== e.redir) begin
                n_fail++;
                $display("FAIL flush_ifid got %b exp %b t=%0t", flush_ifid, e.redir, $time);
            end
            if (flush_idex !== e.redir) begin
                n_fail++;
                $display("FAIL flush_idex got %b exp %b t=%0t", flush_idex, e.redir, $time);
            end
            if (e.redir || e.ck_pc) begin
                n_checks++;
                if (redirect_pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL redirect_pc got %h exp %h t=%0t", redirect_pc, e.pc, $time);
                end
            end
            if (e.ck_pred) begin
                n_checks++;
                if (pred_taken !== e.pred) begin
                    n_fail++;
                    $display("FAIL pred_taken pc=%h got %b exp %b t=%0t",
                             if_pc, pred_taken, e.pred, $time);
                end
            end
        end else if (started) begin
            n_checks++;
            if (redirect !== 1'b0) begin
                n_fail++;
                $display("FAIL unexpected_redirect got %b exp 0 t=%0t", redirect, $time);
            end
        end
    end

    task automatic clr();
        ex_valid      = 1'b0;
        stall         = 1'b0;
        ex_pc         = '0;
        ex_branch     = 1'b0;
        ex_jump       = 1'b0;
        ex_funct3     = 3'b000;
        ex_alu_result = '0;
        ex_pred_taken = 1'b0;
        ex_target     = '0;
        ex_pc_plus4   = '0;
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] f3,
                      input logic [31:0] alu, input bit pr,
                      input logic [31:0] tgt);
        ex_valid      = 1'b1;
        ex_branch     = 1'b1;
        ex_jump       = 1'b0;
        ex_pc         = pc;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_pred_taken = pr;
        ex_target     = tgt;
        ex_pc_plus4   = pc + 32'd4;
    endtask

    task automatic step(input bit r, input logic [31:0] p, input bit cp,
                        input bit pd, input bit cpd);
        exp_t e;
        e.redir   = r;
        e.pc      = p;
        e.ck_pc   = cp;
        e.pred    = pd;
        e.ck_pred = cpd;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        if_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        started = 1;

        // reset state, predictions weakly not-taken
        if_pc = 32'h0;   step(0, 32'h0, 1, 0, 1);
        if_pc = 32'h4;   step(0, 32'h0, 1, 0, 1);
        if_pc = 32'h100; step(0, 32'h0, 1, 0, 1);

        // BEQ taken, predicted not taken
        if_pc = 32'h10;
        br(32'h10, 3'b000, 32'h0, 0, 32'h40);  step(0, 0, 0, 0, 1);
        // wrong-path branch in REDIRECT must be ignored
        br(32'h10, 3'b001, 32'h0, 1, 32'h90);  step(1, 32'h40, 1, 1, 1);
        clr();                                  step(0, 0, 0, 1, 1);

        // BNE not taken, predicted taken, then saturate at 00
        if_pc = 32'h20;
        br(32'h20, 3'b001, 32'h0, 1, 32'h80);  step(0, 0, 0, 0, 1);
        clr();                                  step(1, 32'h24, 1, 0, 1);
        br(32'h20, 3'b001, 32'h0, 0, 32'h80);  step(0, 0, 0, 0, 1);
        br(32'h20, 3'b001, 32'h0, 0, 32'h80);  step(0, 0, 0, 0, 1);
        clr();                                  step(0, 0, 0, 0, 1);

        // BLT taken, predicted taken, saturate at 11
        if_pc = 32'h30;
        br(32'h30, 3'b100, 32'h1, 1, 32'hC0);  step(0, 0, 0, 0, 1);
        br(32'h30, 3'b100, 32'h1, 1, 32'hC0);  step(0, 0, 0, 1, 1);
        br(32'h30, 3'b100, 32'h1, 1, 32'hC0);  step(0, 0, 0, 1, 1);
        // BGE not taken, predicted taken: 11 -> 10
        br(32'h30, 3'b101, 32'h1, 1, 32'hC0);  step(0, 0, 0, 1, 1);
        clr();                                  step(1, 32'h34, 1, 1, 1);
        clr();                                  step(0, 0, 0, 1, 1);

        // stall blocks resolution, then stall holds REDIRECT
        if_pc = 32'h40;
        br(32'h40, 3'b000, 32'h0, 0, 32'h100);
        stall = 1'b1;                           step(0, 0, 0, 0, 1);
        stall = 1'b0;                           step(0, 0, 0, 0, 1);
        clr(); stall = 1'b1;                    step(1, 32'h100, 1, 1, 1);
        stall = 1'b1;                           step(1, 32'h100, 1, 1, 1);
        stall = 1'b0;                           step(1, 32'h100, 1, 1, 1);
        clr();                                  step(0, 0, 0, 1, 1);

        // JAL mispredicted; jumps never train the BHT
        if_pc = 32'h50;
        clr();
        ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 32'h50;
        ex_target = 32'h200; ex_pc_plus4 = 32'h54;
        step(0, 0, 0, 0, 1);
        clr();                                  step(1, 32'h200, 1, 0, 1);
        // branch+jump together resolves as a jump
        br(32'h50, 3'b000, 32'h5, 1, 32'h300);
        ex_jump = 1'b1;                         step(0, 0, 0, 0, 1);
        clr();                                  step(0, 0, 0, 0, 1);

        // reset while in REDIRECT
        if_pc = 32'h10;
        br(32'h10, 3'b000, 32'h0, 0, 32'h40);  step(0, 0, 0, 1, 1);
        clr(); reset = 1'b1;                    step(1, 32'h40, 1, 1, 1);
        reset = 1'b0;                           step(0, 32'h0, 1, 0, 1);
        if_pc = 32'h30;                         step(0, 32'h0, 1, 0, 1);

        // five resolved branches, two mispredicts
        br(32'h70, 3'b000, 32'h0, 1, 32'h400); step(0, 0, 0, 0, 0);
        br(32'h70, 3'b000, 32'h0, 1, 32'h400); step(0, 0, 0, 0, 0);
        br(32'h70, 3'b000, 32'h0, 1, 32'h400); step(0, 0, 0, 0, 0);
        br(32'h70, 3'b000, 32'h1, 1, 32'h400); step(0, 0, 0, 0, 0);
        clr();                                  step(1, 32'h74, 1, 0, 0);
        br(32'h70, 3'b001, 32'h0, 1, 32'h400); step(0, 0, 0, 0, 0);
        clr();                                  step(1, 32'h74, 1, 0, 0);
        clr();                                  step(0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left exp 0", q.size());
        end
`ifdef BR_STATS_EN
        n_checks += 2;
        if (stat_branches !== 32'd5) begin
            n_fail++;
            $display("FAIL stat_branches got %0d exp 5", stat_branches);
        end
        if (stat_mispred !== 32'd2) begin
            n_fail++;
            $display("FAIL stat_mispred got %0d exp 2", stat_mispred);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
